// File: rtl/mc_main_control.sv
// ---------------------------------------------------------------------------
// mc_main_control
//   Multi-cycle main control FSM for the MIPS datapath. Decodes the opcode
//   held in the instruction register, sequences every datapath enable and mux
//   select cycle by cycle, produces the 2-bit ALUop for the downstream ALU
//   function decoder, stalls on the memory-ready handshake and counts retired
//   instructions.
//
// Ports
//   clk         : system clock, rising edge
//   rst         : asynchronous active-high reset
//   Op          : opcode field of the instruction register (valid from DECODE)
//   mem_ready   : memory completes the current access this cycle
//   MemWrite    : memory write strobe
//   IorD        : memory address select (0 PC, 1 ALUOut)
//   IRWrite     : instruction register load
//   PCWrite     : unconditional PC load
//   Branch      : PC load if Zero (beq)
//   BranchNe    : PC load if !Zero (bne)
//   RegDst      : write register select (0 rt, 1 rd)
//   MemtoReg    : write-back data select (0 ALUOut, 1 memory data)
//   RegWrite    : register file write
//   ALUSrcA     : ALU A select (0 PC, 1 regA)
//   ALUSrcB     : ALU B select (00 regB, 01 4, 10 imm, 11 imm<<2)
//   PCSrc       : next PC select (00 ALU, 01 ALUOut, 10 jump target)
//   ALUop       : 00 add, 01 sub, 10 use funct, 11 slt
//   illegal_op  : one-cycle pulse on an unknown opcode in DECODE
//   state_dbg   : current state encoding
//   instr_cnt   : retired instruction count, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module mc_main_control #(
    parameter int          CNT_W   = 32,
    parameter logic [5:0]  OP_LW   = 6'b100011,
    parameter logic [5:0]  OP_SW   = 6'b101011,
    parameter logic [5:0]  OP_R    = 6'b000000,
    parameter logic [5:0]  OP_BEQ  = 6'b000100,
    parameter logic [5:0]  OP_BNE  = 6'b000101,
    parameter logic [5:0]  OP_ADDI = 6'b001000,
    parameter logic [5:0]  OP_SLTI = 6'b001010,
    parameter logic [5:0]  OP_J    = 6'b000010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Op,
    input  logic             mem_ready,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             Branch,
    output logic             BranchNe,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic [1:0]       ALUop,
    output logic             illegal_op,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    // Write-type strobes are produced here ungated and masked by reset below,
    // so nothing that changes architectural state can fire while rst is high.
    logic memWriteRaw, irWriteRaw, pcWriteRaw, regWriteRaw;
    logic branchRaw, branchNeRaw, illegalRaw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        retire      = 1'b0;
        memWriteRaw = 1'b0;
        irWriteRaw  = 1'b0;
        pcWriteRaw  = 1'b0;
        regWriteRaw = 1'b0;
        branchRaw   = 1'b0;
        branchNeRaw = 1'b0;
        illegalRaw  = 1'b0;
        IorD        = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSrc       = 2'b00;
        ALUop       = 2'b00;

        unique case (state_q)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                // IR load and PC+4 commit only once memory returns the word
                irWriteRaw = mem_ready;
                pcWriteRaw = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target PC + (imm<<2) is precomputed into ALUOut here
                ALUSrcB = 2'b11;
                op_d    = Op;
                case (Op)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_R:             state_d = S_EXECUTE;
                    OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                    OP_ADDI, OP_SLTI: state_d = S_IMMEX;
                    OP_J:             state_d = S_JUMP;
                    default: begin
                        state_d    = S_FETCH;
                        illegalRaw = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                MemtoReg    = 1'b1;
                regWriteRaw = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWR: begin
                IorD        = 1'b1;
                memWriteRaw = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst      = 1'b1;
                regWriteRaw = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUop       = 2'b01;
                PCSrc       = 2'b01;
                branchRaw   = (op_q == OP_BEQ);
                branchNeRaw = (op_q == OP_BNE);
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUop   = (op_q == OP_SLTI) ? 2'b11 : 2'b00;
                state_d = S_IMMWB;
            end
            S_IMMWB: begin
                regWriteRaw = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCSrc      = 2'b10;
                pcWriteRaw = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                // Encodings 12-15 are never entered normally; recover quietly
                state_d = S_FETCH;
            end
        endcase

        cnt_d = retire ? (cnt_q + CNT_W'(1)) : cnt_q;
    end

    assign MemWrite   = memWriteRaw & ~rst;
    assign IRWrite    = irWriteRaw  & ~rst;
    assign PCWrite    = pcWriteRaw  & ~rst;
    assign RegWrite   = regWriteRaw & ~rst;
    assign Branch     = branchRaw   & ~rst;
    assign BranchNe   = branchNeRaw & ~rst;
    assign illegal_op = illegalRaw  & ~rst;

    assign state_dbg  = state_q;
    assign instr_cnt  = cnt_q;

endmodule

// File: tb/tb_mc_main_control.sv
// ---------------------------------------------------------------------------
// tb_mc_main_control
//   Scoreboard bench for mc_main_control. The driver applies one cycle of
//   inputs at a time and queues the hand-computed expected state, control
//   vector and retired count for that cycle; an independent monitor pops one
//   entry each falling edge and compares it with the DUT outputs.
//   The counter width is reduced to 3 bits so wrap-around is reached.
// ---------------------------------------------------------------------------
module tb_mc_main_control;

    localparam int CNT_W = 3;

    // State encodings
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_IMMEX   = 4'd9;
    localparam logic [3:0] S_IMMWB   = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    // Control vector layout:
    // {MemWrite, IorD, IRWrite, PCWrite, Branch, BranchNe, RegDst, MemtoReg,
    //  RegWrite, ALUSrcA, ALUSrcB[1:0], PCSrc[1:0], ALUop[1:0], illegal_op}
    localparam logic [16:0] C_RST      = 17'b0_0_0_0_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_FETCH0   = 17'b0_0_0_0_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_FETCH1   = 17'b0_0_1_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_DEC      = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] C_DEC_ILL  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] C_MEMADR   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_MEMRD    = 17'b0_1_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_MEMWB    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] C_MEMWR    = 17'b1_1_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_EXECUTE  = 17'b0_0_0_0_0_0_0_0_0_1_00_00_10_0;
    localparam logic [16:0] C_ALUWB    = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] C_BEQ      = 17'b0_0_0_0_1_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] C_BNE      = 17'b0_0_0_0_0_1_0_0_0_1_00_01_01_0;
    localparam logic [16:0] C_IMMEX_SL = 17'b0_0_0_0_0_0_0_0_0_1_10_00_11_0;
    localparam logic [16:0] C_IMMEX_AD = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_IMMWB    = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [16:0] C_JUMP     = 17'b0_0_0_1_0_0_0_0_0_0_00_10_00_0;

    typedef struct packed {
        logic [3:0]       st;
        logic [16:0]      ctrl;
        logic [CNT_W-1:0] cnt;
    } expRec_t;

    logic             clk;
    logic             rst;
    logic [5:0]       Op;
    logic             mem_ready;
    logic             MemWrite, IorD, IRWrite, PCWrite, Branch, BranchNe;
    logic             RegDst, MemtoReg, RegWrite, ALUSrcA, illegal_op;
    logic [1:0]       ALUSrcB, PCSrc, ALUop;
    logic [3:0]       state_dbg;
    logic [CNT_W-1:0] instr_cnt;
    logic [16:0]      actCtrl;

    expRec_t sb[$];
    string   tagQ[$];
    int      checks = 0;
    int      errors = 0;

    mc_main_control #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .Op         (Op),
        .mem_ready  (mem_ready),
        .MemWrite   (MemWrite),
        .IorD       (IorD),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .Branch     (Branch),
        .BranchNe   (BranchNe),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUop      (ALUop),
        .illegal_op (illegal_op),
        .state_dbg  (state_dbg),
        .instr_cnt  (instr_cnt)
    );

    assign actCtrl = {MemWrite, IorD, IRWrite, PCWrite, Branch, BranchNe,
                      RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSrc,
                      ALUop, illegal_op};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one field and tally the result
    task automatic checkOutput(input string tag, input string field,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s actual=%0h expected=%0h at %0t",
                     tag, field, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs and queue what the DUT must show this cycle
    task automatic applyStimulus(input logic r, input logic m, input logic [5:0] o,
                                 input logic [3:0] st, input logic [16:0] c,
                                 input logic [CNT_W-1:0] n, input string tag);
        expRec_t rec;
        rst       = r;
        mem_ready = m;
        Op        = o;
        rec.st    = st;
        rec.ctrl  = c;
        rec.cnt   = n;
        sb.push_back(rec);
        tagQ.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expected cycle is retired per falling edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            expRec_t rec;
            string   tag;
            rec = sb.pop_front();
            tag = tagQ.pop_front();
            checkOutput(tag, "state", 32'(state_dbg), 32'(rec.st));
            checkOutput(tag, "ctrl",  32'(actCtrl),   32'(rec.ctrl));
            checkOutput(tag, "cnt",   32'(instr_cnt), 32'(rec.cnt));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        Op        = 6'b000000;
        @(posedge clk);
        #1;

        // Reset: strobes masked even though mem_ready is high
        applyStimulus(1, 1, 6'b000000, S_FETCH, C_RST, 0, "reset0");
        applyStimulus(1, 1, 6'b000000, S_FETCH, C_RST, 0, "reset1");

        // lw: 5 cycles
        applyStimulus(0, 1, 6'b100011, S_FETCH,   C_FETCH1, 0, "lw.fetch");
        applyStimulus(0, 1, 6'b100011, S_DECODE,  C_DEC,    0, "lw.decode");
        applyStimulus(0, 1, 6'b100011, S_MEMADR,  C_MEMADR, 0, "lw.memadr");
        applyStimulus(0, 1, 6'b100011, S_MEMRD,   C_MEMRD,  0, "lw.memrd");
        applyStimulus(0, 1, 6'b100011, S_MEMWB,   C_MEMWB,  0, "lw.memwb");

        // R-type: 4 cycles
        applyStimulus(0, 1, 6'b000000, S_FETCH,   C_FETCH1,  1, "r.fetch");
        applyStimulus(0, 1, 6'b000000, S_DECODE,  C_DEC,     1, "r.decode");
        applyStimulus(0, 1, 6'b000000, S_EXECUTE, C_EXECUTE, 1, "r.execute");
        applyStimulus(0, 1, 6'b000000, S_ALUWB,   C_ALUWB,   1, "r.aluwb");

        // sw with 3 wait cycles in MEMWR
        applyStimulus(0, 1, 6'b101011, S_FETCH,  C_FETCH1, 2, "sw.fetch");
        applyStimulus(0, 1, 6'b101011, S_DECODE, C_DEC,    2, "sw.decode");
        applyStimulus(0, 1, 6'b101011, S_MEMADR, C_MEMADR, 2, "sw.memadr");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 6'b101011, S_MEMWR, C_MEMWR, 2, "sw.memwr_wait");
        end
        applyStimulus(0, 1, 6'b101011, S_MEMWR, C_MEMWR, 2, "sw.memwr_done");

        // slti then addi
        applyStimulus(0, 1, 6'b001010, S_FETCH,  C_FETCH1,   3, "slti.fetch");
        applyStimulus(0, 1, 6'b001010, S_DECODE, C_DEC,      3, "slti.decode");
        applyStimulus(0, 1, 6'b001010, S_IMMEX,  C_IMMEX_SL, 3, "slti.immex");
        applyStimulus(0, 1, 6'b001010, S_IMMWB,  C_IMMWB,    3, "slti.immwb");
        applyStimulus(0, 1, 6'b001000, S_FETCH,  C_FETCH1,   4, "addi.fetch");
        applyStimulus(0, 1, 6'b001000, S_DECODE, C_DEC,      4, "addi.decode");
        applyStimulus(0, 1, 6'b001000, S_IMMEX,  C_IMMEX_AD, 4, "addi.immex");
        applyStimulus(0, 1, 6'b001000, S_IMMWB,  C_IMMWB,    4, "addi.immwb");

        // beq, bne, j: 3 cycles each; j retirement wraps 7 -> 0
        applyStimulus(0, 1, 6'b000100, S_FETCH,  C_FETCH1, 5, "beq.fetch");
        applyStimulus(0, 1, 6'b000100, S_DECODE, C_DEC,    5, "beq.decode");
        applyStimulus(0, 1, 6'b000100, S_BRANCH, C_BEQ,    5, "beq.branch");
        applyStimulus(0, 1, 6'b000101, S_FETCH,  C_FETCH1, 6, "bne.fetch");
        applyStimulus(0, 1, 6'b000101, S_DECODE, C_DEC,    6, "bne.decode");
        applyStimulus(0, 1, 6'b000101, S_BRANCH, C_BNE,    6, "bne.branch");
        applyStimulus(0, 1, 6'b000010, S_FETCH,  C_FETCH1, 7, "j.fetch");
        applyStimulus(0, 1, 6'b000010, S_DECODE, C_DEC,    7, "j.decode");
        applyStimulus(0, 1, 6'b000010, S_JUMP,   C_JUMP,   7, "j.jump");

        // FETCH stall, then an illegal opcode
        applyStimulus(0, 0, 6'b111111, S_FETCH,  C_FETCH0,  0, "ill.stall");
        applyStimulus(0, 1, 6'b111111, S_FETCH,  C_FETCH1,  0, "ill.fetch");
        applyStimulus(0, 1, 6'b111111, S_DECODE, C_DEC_ILL, 0, "ill.decode");
        applyStimulus(0, 0, 6'b111111, S_FETCH,  C_FETCH0,  0, "ill.back");

        // addi to move the count off zero, then reset in the middle of sw
        applyStimulus(0, 1, 6'b001000, S_FETCH,  C_FETCH1,   0, "addi2.fetch");
        applyStimulus(0, 1, 6'b001000, S_DECODE, C_DEC,      0, "addi2.decode");
        applyStimulus(0, 1, 6'b001000, S_IMMEX,  C_IMMEX_AD, 0, "addi2.immex");
        applyStimulus(0, 1, 6'b001000, S_IMMWB,  C_IMMWB,    0, "addi2.immwb");
        applyStimulus(0, 1, 6'b101011, S_FETCH,  C_FETCH1,   1, "sw2.fetch");
        applyStimulus(0, 1, 6'b101011, S_DECODE, C_DEC,      1, "sw2.decode");
        applyStimulus(0, 1, 6'b101011, S_MEMADR, C_MEMADR,   1, "sw2.memadr");
        applyStimulus(0, 0, 6'b101011, S_MEMWR,  C_MEMWR,    1, "sw2.memwr");
        // rst rises between clock edges: abort must be visible immediately
        applyStimulus(1, 1, 6'b101011, S_FETCH,  C_RST,      0, "sw2.async_rst");

        // Normal operation resumes after reset
        applyStimulus(0, 1, 6'b000000, S_FETCH,   C_FETCH1,  0, "r2.fetch");
        applyStimulus(0, 1, 6'b000000, S_DECODE,  C_DEC,     0, "r2.decode");
        applyStimulus(0, 1, 6'b000000, S_EXECUTE, C_EXECUTE, 0, "r2.execute");
        applyStimulus(0, 1, 6'b000000, S_ALUWB,   C_ALUWB,   0, "r2.aluwb");
        applyStimulus(0, 0, 6'b000000, S_FETCH,   C_FETCH0,  1, "r2.retired");

        // Let the monitor drain the queue within a bounded number of cycles
        for (int i = 0; i < 4 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain pending=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multi-cycle main control FSM for the MIPS datapath.
- Decodes the 6-bit opcode from the instruction register and sequences every datapath enable and mux select per cycle.
- Generates the 2-bit ALUop that the ALU function decoder consumes directly downstream.
- Stalls on a memory-ready handshake and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_R, 6'b000000, R-type opcode
OP_BEQ, 6'b000100, branch-equal opcode
OP_BNE, 6'b000101, branch-not-equal opcode
OP_ADDI, 6'b001000, add-immediate opcode
OP_SLTI, 6'b001010, set-less-than-immediate opcode
OP_J, 6'b000010, jump opcode

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
Op  in  6  opcode field of instruction register; valid from DECODE onward
mem_ready  in  1  memory completes current access this cycle
MemWrite  out  1  memory write strobe
IorD  out  1  0: address=PC, 1: address=ALUOut
IRWrite  out  1  instruction register load
PCWrite  out  1  unconditional PC load
Branch  out  1  PC load if Zero (beq)
BranchNe  out  1  PC load if !Zero (bne)
RegDst  out  1  0: rt, 1: rd
MemtoReg  out  1  0: ALUOut, 1: memory data
RegWrite  out  1  register file write
ALUSrcA  out  1  0: PC, 1: regA
ALUSrcB  out  2  00: regB, 01: const 4, 10: sign-ext imm, 11: sign-ext imm<<2
PCSrc  out  2  00: ALU result, 01: ALUOut, 10: jump target
ALUop  out  2  00 add, 01 sub, 10 use funct, 11 slt
illegal_op  out  1  one-cycle pulse on an unknown opcode
state_dbg  out  4  current state encoding
instr_cnt  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11.
- Codes 12-15 are unreachable. If entered, they go to FETCH next cycle with all outputs 0.
- Reset: rst high sets state=FETCH, op_q=0, instr_cnt=0 asynchronously. While rst is high, MemWrite, IRWrite, PCWrite, RegWrite, Branch, BranchNe and illegal_op are forced to 0.
- Outputs are Moore, decoded from state and op_q. The exceptions are the mem_ready gating noted below and the Op-based illegal_op decode in DECODE. Any output not listed for a state is 0.
- FETCH: ALUSrcB=01, ALUop=00, IorD=0, PCSrc=00.
  - IRWrite = PCWrite = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcB=11, ALUop=00 (branch target precompute). Latch Op into op_q. Next state:
  - lw/sw -> MEMADR
  - R -> EXECUTE
  - beq/bne -> BRANCH
  - addi/slti -> IMMEX
  - j -> JUMP
  - other -> FETCH with illegal_op=1 for this cycle; instr_cnt not incremented.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=00. Next MEMRD if op_q=lw, else MEMWR.
- MEMRD: IorD=1. Hold until mem_ready=1, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next FETCH.
- MEMWR: IorD=1, MemWrite=1, held high every cycle until mem_ready=1. Then FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUop=10. Next ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCSrc=01.
  - Branch=1 if op_q=beq; BranchNe=1 if op_q=bne.
  - Next FETCH.
- IMMEX: ALUSrcA=1, ALUSrcB=10. ALUop=00 for addi, 11 for slti. Next IMMWB.
- IMMWB: RegDst=0, MemtoReg=0, RegWrite=1. Next FETCH.
- JUMP: PCSrc=10, PCWrite=1. Next FETCH.
- instr_cnt increments by 1 on every clock edge leaving MEMWB, MEMWR (with mem_ready=1), ALUWB, BRANCH, IMMWB or JUMP. Wraps from all-ones to 0.
- Cycle counts with mem_ready always 1: lw 5, sw 4, R 4, beq/bne 3, addi/slti 4, j 3.
- Reset asserted mid-instruction aborts it immediately. No partial write strobe survives the reset edge. The counter is not incremented.

Test Plan:
- Reset then mem_ready=1, Op=100011 -> states 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4. instr_cnt=1.
- Op=000000 -> ALUop=10 in EXECUTE. ALUWB has RegDst=1, RegWrite=1. Total 4 cycles; instr_cnt increments by 1.
- Op=101011 with mem_ready low for 3 cycles in MEMWR -> MemWrite=1, IorD=1 for 4 cycles. Exit to FETCH on the mem_ready=1 edge; exactly one increment.
- Op=001010 then Op=001000 -> IMMEX shows ALUop=11 then 00. ALUSrcB=10 both times; RegDst=0 in IMMWB.
- Op=000100 / 000101 / 000010 -> BRANCH with Branch=1/BranchNe=0, then Branch=0/BranchNe=1. JUMP has PCSrc=10, PCWrite=1. Each takes 3 cycles.
- Op=111111 in DECODE -> illegal_op pulses 1 cycle, state returns to 0, instr_cnt unchanged. Separately: rst asserted during MEMWR forces MemWrite=0 asynchronously and state_dbg=0.
